// File: rtl/motion_cmd_gen.sv
// motion_cmd_gen: debounces up/down buttons into pending requests
// and arbitrates them into go_up/go_down levels for the motion FSM.
package motion_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_UP    = 2'b01,
    S_DOWN  = 2'b10,
    S_DWELL = 2'b11
  } cmd_state_t;

endpackage

module motion_cmd_deb #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic CLK,
  input  logic halt,
  input  logic btn,
  output logic rise
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             deb;
  logic             deb_q;

  always_ff @(posedge CLK or posedge halt) begin
    if (halt) begin
      cnt   <= '0;
      deb_q <= 1'b0;
    end else begin
      deb_q <= deb;
      if (!btn)
        cnt <= '0;
      else if (cnt != DEB_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // one pulse per accepted press, however long it is held
  assign deb  = (cnt == DEB_MAX);
  assign rise = deb & ~deb_q;

endmodule

module motion_cmd_gen
  import motion_cmd_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int DWELL_CYCLES = 2,
  parameter int CNT_W        = 3
) (
  input  logic       CLK,
  input  logic       halt,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       top_lim,
  input  logic       bott_lim,
  output logic       go_up,
  output logic       go_down,
  output logic [1:0] cmd_state,
  output logic [1:0] req_pend
);

  localparam logic [CNT_W-1:0] DWELL_LAST =
    CNT_W'(DWELL_CYCLES - 1);

  cmd_state_t       state;
  cmd_state_t       state_nxt;
  logic             req_up;
  logic             req_dn;
  logic             rise_up;
  logic             rise_dn;
  logic             clr_up;
  logic             clr_dn;
  logic [CNT_W-1:0] dwell_cnt;
  logic             dwell_done;

  motion_cmd_deb #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_up (
    .CLK  (CLK),
    .halt (halt),
    .btn  (btn_up),
    .rise (rise_up)
  );

  motion_cmd_deb #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_dn (
    .CLK  (CLK),
    .halt (halt),
    .btn  (btn_down),
    .rise (rise_dn)
  );

  assign dwell_done = (dwell_cnt == DWELL_LAST);

  always_ff @(posedge CLK or posedge halt) begin
    if (halt)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_up    = 1'b0;
    clr_dn    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (top_lim && bott_lim) begin
          clr_up = 1'b1;
          clr_dn = 1'b1;
        end else if (req_up) begin
          if (top_lim)
            clr_up = 1'b1;
          else
            state_nxt = S_UP;
        end else if (req_dn) begin
          if (bott_lim)
            clr_dn = 1'b1;
          else
            state_nxt = S_DOWN;
        end
      end
      S_UP: begin
        if (top_lim && bott_lim) begin
          state_nxt = S_DWELL;
          clr_up    = 1'b1;
          clr_dn    = 1'b1;
        end else if (top_lim || req_dn) begin
          state_nxt = S_DWELL;
          clr_up    = 1'b1;
        end
      end
      S_DOWN: begin
        if (top_lim && bott_lim) begin
          state_nxt = S_DWELL;
          clr_up    = 1'b1;
          clr_dn    = 1'b1;
        end else if (bott_lim || req_up) begin
          state_nxt = S_DWELL;
          clr_dn    = 1'b1;
        end
      end
      S_DWELL: begin
        if (dwell_done)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    go_up     = (state == S_UP);
    go_down   = (state == S_DOWN);
    cmd_state = state;
    req_pend  = {req_dn, req_up};
  end

  // a fresh press overrides any clear issued by the FSM on the same edge
  always_ff @(posedge CLK or posedge halt) begin
    if (halt) begin
      req_up <= 1'b0;
      req_dn <= 1'b0;
    end else begin
      unique case (1'b1)
        rise_up && !rise_dn: begin
          req_up <= 1'b1;
          req_dn <= 1'b0;
        end
        rise_dn && !rise_up: begin
          req_up <= 1'b0;
          req_dn <= 1'b1;
        end
        default: begin
          req_up <= req_up & ~clr_up;
          req_dn <= req_dn & ~clr_dn;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge halt) begin
    if (halt)
      dwell_cnt <= '0;
    else if (state == S_DWELL && !dwell_done)
      dwell_cnt <= dwell_cnt + 1'b1;
    else
      dwell_cnt <= '0;
  end

endmodule

// File: tb/tb_motion_cmd_gen.sv
// tb_motion_cmd_gen: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of the command stage.
module tb_motion_cmd_gen;

  localparam int DEB   = 4;
  localparam int DWELL = 2;
  localparam int ST_IDLE  = 0;
  localparam int ST_UP    = 1;
  localparam int ST_DOWN  = 2;
  localparam int ST_DWELL = 3;

  logic       CLK      = 1'b0;
  logic       halt     = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_down = 1'b0;
  logic       top_lim  = 1'b0;
  logic       bott_lim = 1'b0;
  logic       go_up;
  logic       go_down;
  logic [1:0] cmd_state;
  logic [1:0] req_pend;

  int checks = 0;
  int errors = 0;

  motion_cmd_gen #(
    .DEB_CYCLES   (DEB),
    .DWELL_CYCLES (DWELL),
    .CNT_W        (3)
  ) dut (
    .CLK       (CLK),
    .halt      (halt),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .top_lim   (top_lim),
    .bott_lim  (bott_lim),
    .go_up     (go_up),
    .go_down   (go_down),
    .cmd_state (cmd_state),
    .req_pend  (req_pend)
  );

  always #100 CLK = ~CLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: run = consecutive 1-samples since the last 0; a press is
  // accepted on the edge where the run seen so far is exactly DEB long
  int run_u = 0;
  int run_d = 0;
  int m_st  = ST_IDLE;
  int m_dw  = 0;
  bit m_ru  = 0;
  bit m_rd  = 0;

  task automatic model_step();
    bit rise_u, rise_d, nu, nd;
    int ns;
    rise_u = (run_u == DEB);
    rise_d = (run_d == DEB);
    run_u  = btn_up   ? ((run_u < 255) ? run_u + 1 : 255) : 0;
    run_d  = btn_down ? ((run_d < 255) ? run_d + 1 : 255) : 0;
    nu = m_ru;
    nd = m_rd;
    ns = m_st;
    if (m_st == ST_IDLE) begin
      if (top_lim && bott_lim) begin
        nu = 0; nd = 0;
      end else if (m_ru) begin
        if (top_lim) nu = 0; else ns = ST_UP;
      end else if (m_rd) begin
        if (bott_lim) nd = 0; else ns = ST_DOWN;
      end
    end else if (m_st == ST_UP) begin
      if (top_lim || m_rd) begin
        ns = ST_DWELL; nu = 0;
        if (top_lim && bott_lim) nd = 0;
      end
    end else if (m_st == ST_DOWN) begin
      if (bott_lim || m_ru) begin
        ns = ST_DWELL; nd = 0;
        if (top_lim && bott_lim) nu = 0;
      end
    end else begin
      m_dw++;
      if (m_dw == DWELL) ns = ST_IDLE;
    end
    if (ns == ST_DWELL && m_st != ST_DWELL) m_dw = 0;
    if (rise_u && !rise_d) begin
      nu = 1; nd = 0;
    end else if (rise_d && !rise_u) begin
      nd = 1; nu = 0;
    end
    m_st = ns;
    m_ru = nu;
    m_rd = nd;
  endtask

  always @(posedge CLK or posedge halt) begin
    if (halt) begin
      run_u = 0; run_d = 0; m_st = ST_IDLE;
      m_dw = 0; m_ru = 0; m_rd = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge CLK) begin
    chk("go_up", go_up, m_st == ST_UP);
    chk("go_down", go_down, m_st == ST_DOWN);
    chk("cmd_state", cmd_state, m_st[1:0]);
    chk("req_pend", req_pend, {m_rd, m_ru});
    chk("exclusive", go_up & go_down, 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  bit pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    #1 halt = 1'b1;
    // 1: halt held while buttons toggle
    for (int i = 0; i < 6; i++) begin
      btn_up   = i[0];
      btn_down = ~i[0];
      cyc(1);
    end
    chk("t1_go", {go_up, go_down}, 0);
    chk("t1_state", cmd_state, 0);
    chk("t1_req", req_pend, 0);
    btn_up = 0; btn_down = 0;
    cyc(1);
    halt = 0;
    cyc(2);

    // 2: held press, single request, top limit
    btn_up = 1;
    cyc(5);
    chk("t2_e5_go", go_up, 0);
    chk("t2_e5_req", req_pend, 2'b01);
    cyc(1);
    chk("t2_e6_go", go_up, 1);
    cyc(20);
    btn_up = 0; top_lim = 1;
    cyc(1);
    chk("t2_lim_go", go_up, 0);
    chk("t2_lim_st", cmd_state, 2'b11);
    chk("t2_lim_req", req_pend, 0);
    cyc(1);
    chk("t2_dwell2", cmd_state, 2'b11);
    cyc(1);
    chk("t2_idle", cmd_state, 2'b00);
    top_lim = 0;
    cyc(3);
    chk("t2_single", cmd_state, 2'b00);

    // halt mid-UP
    btn_up = 1;
    cyc(4);
    btn_up = 0;
    cyc(2);
    chk("t1_up", cmd_state, 2'b01);
    halt = 1;
    #1;
    chk("t1_async_go", go_up, 0);
    chk("t1_async_st", cmd_state, 0);
    cyc(1);
    halt = 0;
    cyc(1);

    // 3: bouncing press rejected, clean 4-cycle press accepted
    for (int i = 0; i < 8; i++) begin
      btn_up = pat[i];
      cyc(1);
    end
    cyc(3);
    chk("t3_bounce_go", go_up, 0);
    chk("t3_bounce_req", req_pend, 0);
    btn_up = 1;
    cyc(4);
    btn_up = 0;
    cyc(1);
    chk("t3_clean_req", req_pend, 2'b01);
    cyc(1);
    chk("t3_clean_st", cmd_state, 2'b01);

    // 4: reversal from UP
    btn_down = 1;
    cyc(5);
    btn_down = 0;
    chk("t4_req", req_pend, 2'b10);
    chk("t4_still_up", cmd_state, 2'b01);
    cyc(1);
    chk("t4_dw1", cmd_state, 2'b11);
    chk("t4_go_up", go_up, 0);
    cyc(1);
    chk("t4_dw2", cmd_state, 2'b11);
    cyc(1);
    chk("t4_idle", cmd_state, 2'b00);
    cyc(1);
    chk("t4_down", cmd_state, 2'b10);
    bott_lim = 1;
    cyc(1);
    chk("t4_blim", cmd_state, 2'b11);
    cyc(3);
    bott_lim = 0;

    // 5: simultaneous presses ignored; request against top limit dropped
    btn_up = 1; btn_down = 1;
    cyc(8);
    btn_up = 0; btn_down = 0;
    cyc(3);
    chk("t5_both_req", req_pend, 0);
    chk("t5_both_st", cmd_state, 0);
    top_lim = 1; btn_up = 1;
    cyc(5);
    chk("t5_lim_req", req_pend, 2'b01);
    cyc(1);
    chk("t5_drop_req", req_pend, 0);
    btn_up = 0;
    cyc(3);
    chk("t5_drop_go", go_up, 0);
    top_lim = 0;

    // 6: both limits during DOWN
    btn_down = 1;
    cyc(4);
    btn_down = 0;
    cyc(2);
    chk("t6_down", cmd_state, 2'b10);
    top_lim = 1; bott_lim = 1;
    cyc(1);
    chk("t6_dwell", cmd_state, 2'b11);
    chk("t6_req", req_pend, 0);
    cyc(6);
    chk("t6_idle", cmd_state, 2'b00);
    top_lim = 0; bott_lim = 0;
    cyc(2);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
      if (top_lim) top_lim = ($urandom_range(0, 4) != 0);
      else top_lim = ($urandom_range(0, 29) == 0);
      if (bott_lim) bott_lim = ($urandom_range(0, 4) != 0);
      else bott_lim = ($urandom_range(0, 29) == 0);
      halt = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    halt = 0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
